// File: rtl/rsa_job_ctrl.sv
// rsa_job_ctrl: sequences a single RSA encryption job on rsa_unit.
// The controller takes start requests from GPIO or SPI. When both arrive in
// the same cycle it picks one by round-robin. It holds the unit in reset for
// RST_CYCLES cycles, then enables the unit and waits for end-of-conversion.
// A job ends in one of three ways: completion, a stop request, or a watchdog
// timeout. The outcome is reported back to the register file.
module rsa_job_ctrl #(
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 ena,
  input  logic                 gpio_start,
  input  logic                 spi_start,
  input  logic                 gpio_stop,
  input  logic                 spi_stop,
  input  logic [TIMEOUT_W-1:0] timeout_val,
  input  logic                 eoc_rsa_unit,
  output logic                 en_rsa,
  output logic                 rst_rsa,
  output logic                 eoc,
  output logic                 eoc_pulse,
  output logic                 busy,
  output logic                 owner,
  output logic                 timeout_err,
  output logic                 abort_flag
);

  localparam int CLR_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CLR_W-1:0]     CLR_LAST = CLR_W'(RST_CYCLES - 1);
  localparam logic [CLR_W-1:0]     CLR_ONE  = CLR_W'(1);
  localparam logic [CLR_W-1:0]     CLR_ZERO = CLR_W'(0);
  localparam logic [TIMEOUT_W-1:0] WD_ONE   = TIMEOUT_W'(1);
  localparam logic [TIMEOUT_W-1:0] WD_ZERO  = TIMEOUT_W'(0);
  localparam logic [TIMEOUT_W-1:0] WD_MAX   = {TIMEOUT_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_ABORT = 3'd4
  } state_t;

  state_t               state_r;
  logic [CLR_W-1:0]     clr_cnt_r;
  logic [TIMEOUT_W-1:0] wd_cnt_r;
  logic                 gpio_d_r;
  logic                 spi_d_r;
  logic                 gpio_edge_r;
  logic                 spi_edge_r;
  logic                 last_owner_r;
  logic                 en_rsa_r;
  logic                 rst_rsa_r;
  logic                 eoc_r;
  logic                 eoc_pulse_r;
  logic                 busy_r;
  logic                 owner_r;
  logic                 timeout_err_r;
  logic                 abort_flag_r;

  logic                 stop_s;
  logic                 start_s;
  logic                 winner_s;
  logic [TIMEOUT_W-1:0] wd_limit_s;
  logic                 wd_hit_s;

  // Stop/start qualification, round-robin winner and watchdog limit compare.
  always_comb begin
    stop_s     = gpio_stop | spi_stop;
    start_s    = gpio_edge_r | spi_edge_r;
    wd_limit_s = timeout_val - WD_ONE;
    if (gpio_edge_r && spi_edge_r) begin
      winner_s = ~last_owner_r;
    end else if (spi_edge_r) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
    if (timeout_val != WD_ZERO) begin
      wd_hit_s = (wd_cnt_r == wd_limit_s);
    end else begin
      wd_hit_s = 1'b0;
    end
  end

  // Register the start inputs. Each rising edge becomes a one-cycle request pulse.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      gpio_d_r    <= 1'b0;
      spi_d_r     <= 1'b0;
      gpio_edge_r <= 1'b0;
      spi_edge_r  <= 1'b0;
    end else if (ena) begin
      gpio_d_r    <= gpio_start;
      spi_d_r     <= spi_start;
      gpio_edge_r <= gpio_start & ~gpio_d_r;
      spi_edge_r  <= spi_start & ~spi_d_r;
    end
  end

  // Job sequencer: state, counters and all registered status outputs.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_r       <= ST_IDLE;
      clr_cnt_r     <= CLR_ZERO;
      wd_cnt_r      <= WD_ZERO;
      last_owner_r  <= 1'b1;
      en_rsa_r      <= 1'b0;
      rst_rsa_r     <= 1'b0;
      eoc_r         <= 1'b0;
      eoc_pulse_r   <= 1'b0;
      busy_r        <= 1'b0;
      owner_r       <= 1'b0;
      timeout_err_r <= 1'b0;
      abort_flag_r  <= 1'b0;
    end else if (ena) begin
      eoc_pulse_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          en_rsa_r <= 1'b0;
          if (start_s && !stop_s) begin
            state_r       <= ST_CLR;
            owner_r       <= winner_s;
            eoc_r         <= 1'b0;
            timeout_err_r <= 1'b0;
            abort_flag_r  <= 1'b0;
            rst_rsa_r     <= 1'b0;
            busy_r        <= 1'b1;
            clr_cnt_r     <= CLR_ZERO;
          end else begin
            rst_rsa_r <= 1'b1;
            busy_r    <= 1'b0;
          end
        end
        ST_CLR: begin
          if (stop_s) begin
            state_r      <= ST_ABORT;
            abort_flag_r <= 1'b1;
            busy_r       <= 1'b0;
            rst_rsa_r    <= 1'b0;
            en_rsa_r     <= 1'b0;
          end else if (clr_cnt_r == CLR_LAST) begin
            state_r   <= ST_RUN;
            en_rsa_r  <= 1'b1;
            rst_rsa_r <= 1'b1;
            wd_cnt_r  <= WD_ZERO;
          end else begin
            clr_cnt_r <= clr_cnt_r + CLR_ONE;
          end
        end
        ST_RUN: begin
          if (eoc_rsa_unit) begin
            state_r     <= ST_DONE;
            eoc_r       <= 1'b1;
            eoc_pulse_r <= 1'b1;
            en_rsa_r    <= 1'b0;
            busy_r      <= 1'b0;
          end else if (stop_s) begin
            state_r      <= ST_ABORT;
            abort_flag_r <= 1'b1;
            en_rsa_r     <= 1'b0;
            rst_rsa_r    <= 1'b0;
            busy_r       <= 1'b0;
          end else if (wd_hit_s) begin
            state_r       <= ST_ABORT;
            timeout_err_r <= 1'b1;
            en_rsa_r      <= 1'b0;
            rst_rsa_r     <= 1'b0;
            busy_r        <= 1'b0;
          end else if (wd_cnt_r != WD_MAX) begin
            wd_cnt_r <= wd_cnt_r + WD_ONE;
          end
        end
        ST_DONE: begin
          last_owner_r <= owner_r;
          state_r      <= ST_IDLE;
        end
        ST_ABORT: begin
          last_owner_r <= owner_r;
          rst_rsa_r    <= 1'b1;
          state_r      <= ST_IDLE;
        end
        default: begin
          state_r  <= ST_IDLE;
          en_rsa_r <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign en_rsa      = en_rsa_r;
  assign rst_rsa     = rst_rsa_r;
  assign eoc         = eoc_r;
  assign eoc_pulse   = eoc_pulse_r;
  assign busy        = busy_r;
  assign owner       = owner_r;
  assign timeout_err = timeout_err_r;
  assign abort_flag  = abort_flag_r;

endmodule

// File: tb/tb_rsa_job_ctrl.sv
// Testbench for rsa_job_ctrl. Each job issued by the stimulus pushes its
// expected outcome into a scoreboard queue. A monitor measures every job
// (CLR length and en_rsa length) and checks the outcome when busy falls.
module tb_rsa_job_ctrl;

  logic        clk = 1'b0;
  logic        rstb;
  logic        ena;
  logic        gpio_start;
  logic        spi_start;
  logic        gpio_stop;
  logic        spi_stop;
  logic [15:0] timeout_val;
  logic        eoc_rsa_unit;
  logic        en_rsa;
  logic        rst_rsa;
  logic        eoc;
  logic        eoc_pulse;
  logic        busy;
  logic        owner;
  logic        timeout_err;
  logic        abort_flag;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic owner;
    logic eoc;
    logic terr;
    logic aflag;
    int   en_cyc;
    int   clr_cyc;
    logic end_rst;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  rsa_job_ctrl #(.RST_CYCLES(2), .TIMEOUT_W(16)) dut (
    .clk          (clk),
    .rstb         (rstb),
    .ena          (ena),
    .gpio_start   (gpio_start),
    .spi_start    (spi_start),
    .gpio_stop    (gpio_stop),
    .spi_stop     (spi_stop),
    .timeout_val  (timeout_val),
    .eoc_rsa_unit (eoc_rsa_unit),
    .en_rsa       (en_rsa),
    .rst_rsa      (rst_rsa),
    .eoc          (eoc),
    .eoc_pulse    (eoc_pulse),
    .busy         (busy),
    .owner        (owner),
    .timeout_err  (timeout_err),
    .abort_flag   (abort_flag)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push(input logic o, input logic ec, input logic te, input logic af,
                      input int en_c, input int clr_c, input logic er);
    exp_t x;
    x.owner = o; x.eoc = ec; x.terr = te; x.aflag = af;
    x.en_cyc = en_c; x.clr_cyc = clr_c; x.end_rst = er;
    sb.push_back(x);
  endtask

  // Monitor: measure each job while busy, then score it when busy falls.
  logic prev_busy = 1'b0;
  logic post      = 1'b0;
  int   en_cnt    = 0;
  int   clr_cnt   = 0;
  always @(negedge clk) begin
    if (!rstb) begin
      prev_busy = 1'b0; post = 1'b0; en_cnt = 0; clr_cnt = 0;
    end else begin
      if (post) begin
        chk("post_rst_rsa", rst_rsa, 1);
        chk("post_eoc_pulse", eoc_pulse, 0);
        post = 1'b0;
      end
      if (busy) begin
        if (en_rsa) en_cnt++;
        if (!rst_rsa) clr_cnt++;
      end else if (prev_busy) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_job: got a finished job expected none at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("owner", owner, e.owner);
          chk("eoc", eoc, e.eoc);
          chk("eoc_pulse", eoc_pulse, e.eoc);
          chk("timeout_err", timeout_err, e.terr);
          chk("abort_flag", abort_flag, e.aflag);
          chk("en_cycles", en_cnt, e.en_cyc);
          chk("clr_cycles", clr_cnt, e.clr_cyc);
          chk("end_rst_rsa", rst_rsa, e.end_rst);
          post = 1'b1;
        end
        en_cnt = 0; clr_cnt = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic g, input logic s);
    gpio_start = g; spi_start = s;
    tick(1);
    gpio_start = 1'b0; spi_start = 1'b0;
  endtask

  task automatic wait_en();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (en_rsa) begin got = 1'b1; break; end
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL wait_en: got en_rsa low expected high within 30 cycles");
    end
  endtask

  task automatic wait_idle();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (!busy) begin got = 1'b1; break; end
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL wait_idle: got busy high expected low within 60 cycles");
    end
    tick(2);
  endtask

  // Raise eoc_rsa_unit (optionally together with a stop) so it is sampled on RUN cycle n.
  task automatic drive_eoc(input int n, input logic with_stop);
    tick(n - 1);
    eoc_rsa_unit = 1'b1;
    spi_stop = with_stop;
    tick(1);
    eoc_rsa_unit = 1'b0;
    spi_stop = 1'b0;
  endtask

  task automatic drive_stop(input int n);
    tick(n - 1);
    spi_stop = 1'b1;
    tick(1);
    spi_stop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rstb = 1'b0; ena = 1'b1; gpio_start = 1'b0; spi_start = 1'b0;
    gpio_stop = 1'b0; spi_stop = 1'b0; timeout_val = 16'd0; eoc_rsa_unit = 1'b0;
    #12;
    chk("rst_en_rsa", en_rsa, 0);
    chk("rst_rst_rsa", rst_rsa, 0);
    chk("rst_eoc", eoc, 0);
    chk("rst_eoc_pulse", eoc_pulse, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_abort_flag", abort_flag, 0);
    tick(1);
    rstb = 1'b1;
    tick(1);
    chk("idle_rst_rsa", rst_rsa, 1);
    chk("idle_busy", busy, 0);

    // Both sources together after reset: GPIO wins; job completes after 10 RUN cycles.
    push(1'b0, 1'b1, 1'b0, 1'b0, 10, 2, 1'b1);
    start_job(1'b1, 1'b1); wait_en(); drive_eoc(10, 1'b0); wait_idle();

    // Both again: SPI wins this time; the watchdog kills the job after 5 RUN cycles.
    timeout_val = 16'd5;
    push(1'b1, 1'b0, 1'b1, 1'b0, 5, 2, 1'b0);
    start_job(1'b1, 1'b1); wait_en(); wait_idle();
    timeout_val = 16'd0;

    // GPIO alone; the sticky timeout is cleared when the new job is accepted.
    push(1'b0, 1'b1, 1'b0, 1'b0, 4, 2, 1'b1);
    start_job(1'b1, 1'b0); wait_en(); drive_eoc(4, 1'b0); wait_idle();

    // SPI job aborted by spi_stop on its third RUN cycle.
    push(1'b1, 1'b0, 1'b0, 1'b1, 3, 2, 1'b0);
    start_job(1'b0, 1'b1); wait_en(); drive_stop(3); wait_idle();

    // eoc and stop in the same cycle: completion wins and abort_flag is cleared.
    push(1'b1, 1'b1, 1'b0, 1'b0, 2, 2, 1'b1);
    start_job(1'b0, 1'b1); wait_en(); drive_eoc(2, 1'b1); wait_idle();

    // A start while stop is high is dropped; the previous result is untouched.
    gpio_stop = 1'b1;
    start_job(1'b1, 1'b0);
    tick(4);
    chk("drop_busy", busy, 0);
    chk("drop_owner", owner, 1);
    chk("drop_eoc", eoc, 1);
    gpio_stop = 1'b0;
    tick(2);

    // ena low for 4 cycles mid-RUN stretches the watchdog; a start while busy is ignored.
    timeout_val = 16'd8;
    push(1'b0, 1'b0, 1'b1, 1'b0, 12, 2, 1'b0);
    start_job(1'b1, 1'b0); wait_en();
    tick(2);
    ena = 1'b0;
    tick(1);
    chk("frz_en_rsa", en_rsa, 1);
    chk("frz_busy", busy, 1);
    tick(3);
    ena = 1'b1;
    spi_start = 1'b1;
    tick(1);
    spi_start = 1'b0;
    wait_idle();
    timeout_val = 16'd0;
    tick(4);

    // Reset mid-RUN clears every output immediately.
    start_job(1'b1, 1'b0); wait_en();
    tick(3);
    #2;
    rstb = 1'b0;
    #1;
    chk("mid_en_rsa", en_rsa, 0);
    chk("mid_rst_rsa", rst_rsa, 0);
    chk("mid_eoc", eoc, 0);
    chk("mid_eoc_pulse", eoc_pulse, 0);
    chk("mid_busy", busy, 0);
    chk("mid_owner", owner, 0);
    chk("mid_timeout_err", timeout_err, 0);
    chk("mid_abort_flag", abort_flag, 0);
    tick(2);
    rstb = 1'b1;
    tick(1);
    chk("post_reset_rst_rsa", rst_rsa, 1);
    chk("post_reset_busy", busy, 0);

    // Round-robin pointer restored to SPI by reset: GPIO wins a simultaneous start.
    push(1'b0, 1'b1, 1'b0, 1'b0, 1, 2, 1'b1);
    start_job(1'b1, 1'b1); wait_en(); drive_eoc(1, 1'b0); wait_idle();

    tick(3);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
